// File: rtl/lpc_host_arbiter.sv
// Two-requester round-robin arbiter in front of an LPC host controller.
// Each granted request runs one START/CYC handshake with the controller. A
// timeout ends the cycle with an error and forces a host reset sequence.
// All outputs are registered and decoded from the next state. As a result,
// done/err/rdata appear on the clock edge that leaves CYC.
module lpc_host_arbiter #(
    parameter int unsigned TIMEOUT    = 100,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_i,
    input  logic [15:0] req0_addr_i,
    input  logic [7:0]  req0_wdata_i,
    input  logic        req0_wr_i,
    input  logic        req0_mem_i,
    input  logic        req1_i,
    input  logic [15:0] req1_addr_i,
    input  logic [7:0]  req1_wdata_i,
    input  logic        req1_wr_i,
    input  logic        req1_mem_i,
    output logic        done0_o,
    output logic        err0_o,
    output logic        done1_o,
    output logic        err1_o,
    output logic [7:0]  rdata_o,
    output logic        busy_o,
    output logic [15:0] host_addr_o,
    output logic [7:0]  host_wdata_o,
    output logic        host_nrst_o,
    output logic        host_lframe_o,
    output logic        host_rd_o,
    output logic        host_wr_o,
    output logic        host_mem_o,
    input  logic [7:0]  host_rdata_i,
    input  logic        host_ready_i
);

    localparam int unsigned TO_W = 8;
    localparam int unsigned RC_W = 4;

    typedef enum logic [2:0] {
        S_HRESET,
        S_IDLE,
        S_START,
        S_CYC,
        S_RECOVER
    } state_t;

    state_t            state_q, state_d;
    logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              rec_q, rec_d;
    logic              prio_q, prio_d;
    logic              owner_q, owner_d;
    logic [15:0]       addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              mem_q, mem_d;
    logic              ready_q;
    logic              ready_rise;
    logic              grant;
    logic              active;

    logic              done0_d, err0_d, done1_d, err1_d;
    logic [7:0]        rdata_d;
    logic              busy_d, nrst_d, lframe_d, hrd_d, hwr_d, hmem_d;
    logic [15:0]       haddr_d;
    logic [7:0]        hwdata_d;

    assign ready_rise = host_ready_i & ~ready_q;

    // State register, transaction latches and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_HRESET;
            rst_cnt_q     <= '0;
            to_cnt_q      <= '0;
            rec_q         <= 1'b0;
            prio_q        <= 1'b0;
            owner_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wr_q          <= 1'b0;
            mem_q         <= 1'b0;
            ready_q       <= 1'b0;
            done0_o       <= 1'b0;
            err0_o        <= 1'b0;
            done1_o       <= 1'b0;
            err1_o        <= 1'b0;
            rdata_o       <= '0;
            busy_o        <= 1'b1;
            host_addr_o   <= '0;
            host_wdata_o  <= '0;
            host_nrst_o   <= 1'b0;
            host_lframe_o <= 1'b1;
            host_rd_o     <= 1'b0;
            host_wr_o     <= 1'b0;
            host_mem_o    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            to_cnt_q      <= to_cnt_d;
            rec_q         <= rec_d;
            prio_q        <= prio_d;
            owner_q       <= owner_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wr_q          <= wr_d;
            mem_q         <= mem_d;
            ready_q       <= host_ready_i;
            done0_o       <= done0_d;
            err0_o        <= err0_d;
            done1_o       <= done1_d;
            err1_o        <= err1_d;
            rdata_o       <= rdata_d;
            busy_o        <= busy_d;
            host_addr_o   <= haddr_d;
            host_wdata_o  <= hwdata_d;
            host_nrst_o   <= nrst_d;
            host_lframe_o <= lframe_d;
            host_rd_o     <= hrd_d;
            host_wr_o     <= hwr_d;
            host_mem_o    <= hmem_d;
        end
    end

    // Next-state, arbitration, completion/timeout and output decode
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        to_cnt_d  = to_cnt_q;
        rec_d     = rec_q;
        prio_d    = prio_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        mem_d     = mem_q;
        grant     = 1'b0;
        done0_d   = 1'b0;
        err0_d    = 1'b0;
        done1_d   = 1'b0;
        err1_d    = 1'b0;
        rdata_d   = '0;

        case (state_q)
            S_HRESET: begin
                if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
                    rst_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end
            S_IDLE: begin
                if (req0_i || req1_i) begin
                    // On a tie, prio_q names the requester that did not own the last grant
                    grant   = (req0_i && req1_i) ? prio_q : req1_i;
                    owner_d = grant;
                    prio_d  = ~grant;
                    addr_d  = grant ? req1_addr_i  : req0_addr_i;
                    wdata_d = grant ? req1_wdata_i : req0_wdata_i;
                    wr_d    = grant ? req1_wr_i    : req0_wr_i;
                    mem_d   = grant ? req1_mem_i   : req0_mem_i;
                    state_d = S_START;
                end
            end
            S_START: begin
                to_cnt_d = '0;
                state_d  = S_CYC;
            end
            S_CYC: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                // Completion is checked first so it beats a same-cycle timeout
                if (ready_rise) begin
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    rdata_d = wr_q ? 8'h00 : host_rdata_i;
                    rec_d   = 1'b0;
                    state_d = S_RECOVER;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    done0_d   = ~owner_q;
                    err0_d    = ~owner_q;
                    done1_d   = owner_q;
                    err1_d    = owner_q;
                    rst_cnt_d = '0;
                    state_d   = S_HRESET;
                end
            end
            S_RECOVER: begin
                if (rec_q) begin
                    state_d = S_IDLE;
                end else begin
                    rec_d = 1'b1;
                end
            end
            default: begin
                rst_cnt_d = '0;
                state_d   = S_HRESET;
            end
        endcase

        active   = (state_d == S_START) || (state_d == S_CYC) || (state_d == S_RECOVER);
        busy_d   = (state_d != S_IDLE);
        nrst_d   = (state_d != S_HRESET);
        lframe_d = (state_d != S_START);
        hrd_d    = (state_d == S_CYC) && !wr_d;
        hwr_d    = (state_d == S_CYC) && wr_d;
        hmem_d   = active && mem_d;
        haddr_d  = active ? addr_d  : 16'h0000;
        hwdata_d = active ? wdata_d : 8'h00;
    end

endmodule

// File: tb/tb_lpc_host_arbiter.sv
// Directed bench for lpc_host_arbiter. The bench drives the host controller
// side directly and uses TIMEOUT=16 and RST_CYCLES=4.
module tb_lpc_host_arbiter;

    localparam int unsigned TO = 16;
    localparam int unsigned RC = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req0_i, req1_i;
    logic [15:0] req0_addr_i, req1_addr_i;
    logic [7:0]  req0_wdata_i, req1_wdata_i;
    logic        req0_wr_i, req1_wr_i, req0_mem_i, req1_mem_i;
    logic        done0_o, err0_o, done1_o, err1_o;
    logic [7:0]  rdata_o;
    logic        busy_o;
    logic [15:0] host_addr_o;
    logic [7:0]  host_wdata_o;
    logic        host_nrst_o, host_lframe_o, host_rd_o, host_wr_o, host_mem_o;
    logic [7:0]  host_rdata_i;
    logic        host_ready_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    lpc_host_arbiter #(.TIMEOUT(TO), .RST_CYCLES(RC)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_i(req0_i), .req0_addr_i(req0_addr_i), .req0_wdata_i(req0_wdata_i),
        .req0_wr_i(req0_wr_i), .req0_mem_i(req0_mem_i),
        .req1_i(req1_i), .req1_addr_i(req1_addr_i), .req1_wdata_i(req1_wdata_i),
        .req1_wr_i(req1_wr_i), .req1_mem_i(req1_mem_i),
        .done0_o(done0_o), .err0_o(err0_o), .done1_o(done1_o), .err1_o(err1_o),
        .rdata_o(rdata_o), .busy_o(busy_o),
        .host_addr_o(host_addr_o), .host_wdata_o(host_wdata_o),
        .host_nrst_o(host_nrst_o), .host_lframe_o(host_lframe_o),
        .host_rd_o(host_rd_o), .host_wr_o(host_wr_o), .host_mem_o(host_mem_o),
        .host_rdata_i(host_rdata_i), .host_ready_i(host_ready_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Advance until the arbiter drives a read or write strobe (CYC), bounded
    task automatic wait_cyc(input string tag);
        int n;
        n = 0;
        while (!(host_rd_o || host_wr_o) && n < 50) begin
            step();
            n++;
        end
        chk(tag, 32'(host_rd_o | host_wr_o), 32'd1);
    endtask

    // Cycles until host_nrst_o returns high, bounded
    task automatic count_nrst_low(output int n);
        n = 0;
        while (!host_nrst_o && n < 50) begin
            step();
            n++;
        end
    endtask

    // One ready rising edge with the given read data; returns on the done cycle
    task automatic complete(input logic [7:0] rd);
        host_rdata_i = rd;
        host_ready_i = 1'b1;
        step();
        host_ready_i = 1'b0;
    endtask

    initial begin
        int n;
        rst_i = 1'b1;
        req0_i = 1'b0; req0_addr_i = '0; req0_wdata_i = '0; req0_wr_i = 1'b0; req0_mem_i = 1'b0;
        req1_i = 1'b0; req1_addr_i = '0; req1_wdata_i = '0; req1_wr_i = 1'b0; req1_mem_i = 1'b0;
        host_rdata_i = '0;
        host_ready_i = 1'b0;

        // Reset values
        repeat (3) step();
        chk("rst_nrst",   32'(host_nrst_o),   32'd0);
        chk("rst_lframe", 32'(host_lframe_o), 32'd1);
        chk("rst_strobe", 32'({host_rd_o, host_wr_o, host_mem_o}), 32'd0);
        chk("rst_busy",   32'(busy_o),        32'd1);
        chk("rst_addr",   32'(host_addr_o),   32'h0000);
        chk("rst_wdata",  32'(host_wdata_o),  32'h00);
        chk("rst_done",   32'({done0_o, err0_o, done1_o, err1_o}), 32'd0);
        chk("rst_rdata",  32'(rdata_o),       32'h00);

        // Reset release: HRESET sequence, then IDLE
        rst_i = 1'b0;
        count_nrst_low(n);
        chk("hreset_len", 32'(n), 32'(RC));
        chk("idle_busy",  32'(busy_o), 32'd0);

        // Simultaneous requests held: grants alternate 0,1,0,1
        req0_addr_i = 16'h0010; req0_wr_i = 1'b0; req0_i = 1'b1;
        req1_addr_i = 16'h0020; req1_wr_i = 1'b0; req1_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_cyc("rr_wait");
            chk("rr_addr", 32'(host_addr_o), (i % 2 == 0) ? 32'h0010 : 32'h0020);
            complete(8'(i + 1));
            chk("rr_done0", 32'(done0_o), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_done1", 32'(done1_o), (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("rr_rdata", 32'(rdata_o), 32'(i + 1));
        end
        req0_i = 1'b0; req1_i = 1'b0;
        step();
        step();
        chk("rr_idle", 32'(busy_o), 32'd0);

        // req0 I/O read at 0080h returning A5h
        req0_addr_i = 16'h0080; req0_wr_i = 1'b0; req0_mem_i = 1'b0; req0_i = 1'b1;
        step();
        chk("rd_start_lframe", 32'(host_lframe_o), 32'd0);
        chk("rd_start_strobe", 32'({host_rd_o, host_wr_o}), 32'd0);
        chk("rd_start_addr",   32'(host_addr_o), 32'h0080);
        step();
        chk("rd_cyc_lframe", 32'(host_lframe_o), 32'd1);
        chk("rd_cyc_rd",     32'({host_rd_o, host_wr_o}), 32'b10);
        step();
        chk("rd_cyc_hold", 32'({host_rd_o, done0_o}), 32'b10);
        complete(8'hA5);
        chk("rd_done",  32'({done0_o, err0_o, done1_o}), 32'b100);
        chk("rd_rdata", 32'(rdata_o), 32'hA5);
        chk("rd_drop",  32'({host_rd_o, host_wr_o}), 32'd0);
        req0_i = 1'b0;
        step();
        chk("rd_pulse", 32'({done0_o, busy_o}), 32'b01);
        step();
        chk("rd_busy_low", 32'(busy_o), 32'd0);

        // req1 memory write at 1234h with 3Ch
        req1_addr_i = 16'h1234; req1_wdata_i = 8'h3C; req1_wr_i = 1'b1; req1_mem_i = 1'b1; req1_i = 1'b1;
        step();
        step();
        chk("wr_strobes", 32'({host_mem_o, host_wr_o, host_rd_o}), 32'b110);
        chk("wr_addr",    32'(host_addr_o),  32'h1234);
        chk("wr_wdata",   32'(host_wdata_o), 32'h3C);
        complete(8'hFF);
        chk("wr_done",  32'({done1_o, err1_o, done0_o}), 32'b100);
        chk("wr_rdata", 32'(rdata_o), 32'h00);
        req1_i = 1'b0; req1_wr_i = 1'b0; req1_mem_i = 1'b0;
        step();
        step();

        // Timeout: host never raises ready
        req0_addr_i = 16'h0055; req0_wr_i = 1'b0; req0_i = 1'b1;
        wait_cyc("to_wait");
        n = 0;
        while (!done0_o && n < 40) begin
            step();
            n++;
        end
        chk("to_latency", 32'(n), 32'(TO));
        chk("to_err",     32'({done0_o, err0_o, done1_o, err1_o}), 32'b1100);
        chk("to_rdata",   32'(rdata_o), 32'h00);
        req0_i = 1'b0;
        count_nrst_low(n);
        chk("to_hreset", 32'(n), 32'(RC));
        req1_addr_i = 16'h0066; req1_wr_i = 1'b0; req1_i = 1'b1;
        wait_cyc("to_next_wait");
        complete(8'h5A);
        chk("to_next_done",  32'({done1_o, err1_o}), 32'b10);
        chk("to_next_rdata", 32'(rdata_o), 32'h5A);
        req1_i = 1'b0;
        step();
        step();

        // Reset during CYC: no done, reset values, full HRESET again
        req0_addr_i = 16'h0077; req0_i = 1'b1;
        wait_cyc("mid_wait");
        rst_i = 1'b1;
        req0_i = 1'b0;
        step();
        chk("mid_done",   32'({done0_o, done1_o, err0_o, err1_o}), 32'd0);
        chk("mid_out",    32'({host_nrst_o, host_lframe_o, host_rd_o, host_wr_o, host_mem_o, busy_o}), 32'b010001);
        chk("mid_addr",   32'(host_addr_o), 32'h0000);
        step();
        rst_i = 1'b0;
        count_nrst_low(n);
        chk("mid_hreset", 32'(n), 32'(RC));
        chk("mid_idle",   32'({busy_o, done0_o}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lpc_host_arbiter.md
LPC_HOST_ARBITER -- requirements
Module: lpc_host_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 100, range 8..255: maximum cycles in CYC awaiting completion before abort.
REQ-002 Parameter RST_CYCLES, default 4, range 1..15: cycles host_nrst_o is held low during a host reset.
REQ-003 clk_i  in  1  single clock for all logic; reset is synchronous and active-high.
REQ-004 rst_i  in  1  synchronous active-high reset.
REQ-005 reqN_i  in  1 (N=0,1)  request; held high, fields stable, until doneN_o.
REQ-006 reqN_addr_i  in  16  I/O or memory address.
REQ-007 reqN_wdata_i  in  8  write data.
REQ-008 reqN_wr_i  in  1  1=write, 0=read.
REQ-009 reqN_mem_i  in  1  1=memory cycle, 0=I/O cycle.
REQ-010 doneN_o  out  1  one-cycle completion pulse to requester N.
REQ-011 errN_o  out  1  valid with doneN_o; 1=aborted by timeout.
REQ-012 rdata_o  out  8  read data, valid while done0_o or done1_o is high.
REQ-013 busy_o  out  1  high in every state except IDLE.
REQ-014 host_addr_o  out  16  to lpc_host ctrl_addr_i.
REQ-015 host_wdata_o  out  8  to ctrl_data_i.
REQ-016 host_nrst_o  out  1  to ctrl_nrst_i.
REQ-017 host_lframe_o  out  1  to ctrl_lframe_i (active low).
REQ-018 host_rd_o  out  1  to ctrl_rd_status_i.
REQ-019 host_wr_o  out  1  to ctrl_wr_status_i.
REQ-020 host_mem_o  out  1  to ctrl_memory_cycle_i.
REQ-021 host_rdata_i  in  8  from ctrl_data_o.
REQ-022 host_ready_i  in  1  from ctrl_ready_o; level signal, may remain high after completion.

Function
REQ-023 FSM states SHALL be HRESET, IDLE, START, CYC, RECOVER.
REQ-024 HRESET SHALL drive host_nrst_o=0 for RST_CYCLES cycles, then enter IDLE; host_nrst_o=1 in all other states.
REQ-025 IDLE SHALL sample requests only in this state; on any request, the FSM SHALL latch owner, addr, wdata, wr and mem into internal registers and enter START on the next cycle.
REQ-026 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester that did not own the last granted transaction; after reset, requester 0 has priority.
REQ-027 START SHALL last exactly one cycle with host_lframe_o=0 and host_rd_o=host_wr_o=0.
REQ-028 CYC SHALL drive host_lframe_o=1, host_rd_o=~wr and host_wr_o=wr, held constant until CYC exits.
REQ-029 host_addr_o, host_wdata_o and host_mem_o SHALL reflect the latched registers in START, CYC and RECOVER.
REQ-030 Completion SHALL be the rising edge of host_ready_i, detected against a registered copy that resets to 0.
REQ-031 On completion in CYC, in that cycle: pulse doneN_o for the owner, errN_o=0, rdata_o=host_rdata_i if the transaction is a read (00h for a write), drop host_rd_o and host_wr_o, and enter RECOVER.
REQ-032 RECOVER SHALL last 2 cycles with strobes inactive, then enter IDLE.
REQ-033 Timeout counter: 8 bits, cleared on entry to CYC, incremented each CYC cycle.
REQ-034 If the counter reaches TIMEOUT without completion: pulse doneN_o and errN_o to the owner, set rdata_o=00h, and enter HRESET.
REQ-035 If completion and timeout occur in the same cycle, completion SHALL win.
REQ-036 The arbiter SHALL ignore host_ready_i outside CYC.
REQ-037 A request withdrawn before done is a protocol violation; the transaction SHALL still complete and the done pulse SHALL still be issued.
REQ-038 A requester holding req high after done SHALL be treated as a new request in the next IDLE.
REQ-039 Round-robin priority SHALL advance on every grant, including grants that end in a timeout.

Reset
REQ-040 While rst_i=1: state=HRESET, RST counter=0, host_nrst_o=0, host_lframe_o=1, host_rd_o=host_wr_o=host_mem_o=0, host_addr_o=0000h, host_wdata_o=00h, done*/err*=0, rdata_o=00h, busy_o=1, priority=requester 0, ready edge register=0.
REQ-041 rst_i asserted mid-transaction SHALL abort the transaction without any done pulse; after release, the FSM SHALL run a full HRESET sequence.

Verification
REQ-042 Release reset with RST_CYCLES=4 -> host_nrst_o low 4 cycles after release, then IDLE with busy_o=0.
REQ-043 req0 I/O read at 0080h, host model returns A5h -> one cycle of host_lframe_o=0, then host_rd_o=1 until ready rises; done0_o=1, err0_o=0, rdata_o=A5h; busy_o low 2 cycles after done.
REQ-044 req0 and req1 both raised in IDLE after reset -> req0 served first, req1 next; with both held continuously, grants alternate 0,1,0,1.
REQ-045 req1 memory write at 1234h with data 3Ch -> host_mem_o=1, host_wr_o=1, host_addr_o=1234h, host_wdata_o=3Ch; done1_o pulses with err1_o=0.
REQ-046 Host never raises ready, TIMEOUT=16 -> done/err pulse 16 cycles after CYC entry, host_nrst_o low 4 cycles; a following request completes normally.
REQ-047 rst_i asserted during CYC -> no done pulse, outputs at reset values, HRESET sequence repeats.
